// File: rtl/usb_ep_fifo_pkg.sv
// Shared default sizing for the USB endpoint FIFO.
// The first-word-fall-through read mode is selected with USB_EP_FIFO_FWFT_EN.
package usb_ep_fifo_pkg;

  localparam int USB_EP_DW       = 8;
  localparam int USB_EP_DEPTH    = 64;
  localparam int USB_EP_AF_LEVEL = 56;
  localparam int USB_EP_AE_LEVEL = 8;

endpackage

// File: rtl/usb_ep_fifo_ram.sv
// DEPTH x DW storage for the endpoint FIFO: one synchronous write port, one read port.
// USB_EP_FIFO_FWFT_EN selects an asynchronous read; otherwise the read word is registered.
module usb_ep_fifo_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

`ifdef USB_EP_FIFO_FWFT_EN
  assign rdata_o = mem_q[raddr_i];
`else
  logic [DW-1:0] rdata_q;

  // Holds the last popped word until the next accepted read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/usb_ep_fifo.sv
// USB endpoint FIFO: pointers, occupancy level, status decodes and sticky error flags.
// Read timing follows USB_EP_FIFO_FWFT_EN (combinational head word) or registered pop data by default.
module usb_ep_fifo
  import usb_ep_fifo_pkg::*;
#(
  parameter int DW       = USB_EP_DW,
  parameter int DEPTH    = USB_EP_DEPTH,
  parameter int AF_LEVEL = USB_EP_AF_LEVEL,
  parameter int AE_LEVEL = USB_EP_AE_LEVEL
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush,
  input  logic                     clr_err,
  input  logic [DW-1:0]            wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     almost_full,
  output logic [DW-1:0]            rd_data,
  input  logic                     rd_en,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
    // A rejection in the same cycle as clr_err keeps the flag set.
    ovf_d = (wr_en & full  & ~flush) | (ovf_q & ~clr_err);
    udf_d = (rd_en & empty & ~flush) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  usb_ep_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_usb_ep_fifo.sv
// Directed, scoreboard-checked bench for usb_ep_fifo (DEPTH=64, DW=8).
// Read-data timing checks follow USB_EP_FIFO_FWFT_EN when it is defined.
module tb_usb_ep_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AFL   = 56;
  localparam int AEL   = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          full, almost_full, empty, almost_empty, ovf, udf;
  logic [DW-1:0] rd_data;
  logic [6:0]    level;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  int         mdl_lvl = 0;
  logic       mdl_ovf = 1'b0;
  logic       mdl_udf = 1'b0;
  logic [7:0] mdl_rd  = 8'h00;
  int         n_push  = 0;
  int         n_pop   = 0;
  logic [7:0] seq     = 8'h00;

  usb_ep_fifo #(
    .DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush(flush), .clr_err(clr_err),
    .wr_data(wr_data), .wr_en(wr_en), .full(full), .almost_full(almost_full),
    .rd_data(rd_data), .rd_en(rd_en), .empty(empty), .almost_empty(almost_empty),
    .level(level), .ovf(ovf), .udf(udf)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("level", 32'(level), 32'(mdl_lvl));
    chk("full", 32'(full), 32'(mdl_lvl == DEPTH));
    chk("empty", 32'(empty), 32'(mdl_lvl == 0));
    chk("almost_full", 32'(almost_full), 32'(mdl_lvl >= AFL));
    chk("almost_empty", 32'(almost_empty), 32'(mdl_lvl <= AEL));
    chk("ovf", 32'(ovf), 32'(mdl_ovf));
    chk("udf", 32'(udf), 32'(mdl_udf));
`ifndef USB_EP_FIFO_FWFT_EN
    chk("rd_data_hold", 32'(rd_data), 32'(mdl_rd));
`endif
  endtask

  // One clock with the given requests; the model decides acceptance from its own level.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic wacc, racc;
    logic [7:0] exp;
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    wacc = w && (mdl_lvl != DEPTH);
    racc = r && (mdl_lvl != 0);
`ifdef USB_EP_FIFO_FWFT_EN
    if (racc) begin
      #1;
      chk("fwft_head", 32'(rd_data), 32'(sb[0]));
    end
`endif
    @(posedge clk_i); #1;
    if (racc) begin
      exp = sb.pop_front();
      mdl_rd = exp;
      n_pop++;
`ifndef USB_EP_FIFO_FWFT_EN
      chk("pop_data", 32'(rd_data), 32'(exp));
`endif
    end
    if (wacc) begin
      sb.push_back(d);
      n_push++;
    end
    if (wacc && !racc) mdl_lvl++;
    if (racc && !wacc) mdl_lvl--;
    if (w && !wacc) mdl_ovf = 1'b1; else if (c) mdl_ovf = 1'b0;
    if (r && !racc) mdl_udf = 1'b1; else if (c) mdl_udf = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    chk_state();
  endtask

  initial begin
    // Reset: outputs settle without any clock edge.
    #2 rst_i = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
`ifndef USB_EP_FIFO_FWFT_EN
    chk("rst_rd_data", 32'(rd_data), 32'd0);
`endif
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk_state();

    // Fill 0x01..0x40 and drain in order.
    for (int i = 1; i <= 64; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_after_64", 32'(full), 32'd1);
    for (int i = 0; i < 64; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_after_64", 32'(empty), 32'd1);

    // Overflow at full, set-wins over clr_err, then clear.
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAB, 1'b0, 1'b0);
    chk("ovf_at_full", 32'(ovf), 32'd1);
    chk("lvl_at_full", 32'(level), 32'd64);
    cycle(1'b1, 8'hAB, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Simultaneous read/write at full, then at empty.
    cycle(1'b1, 8'hCD, 1'b1, 1'b0);
    chk("both_full_lvl", 32'(level), 32'd63);
    chk("both_full_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 63; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("both_empty_lvl", 32'(level), 32'd1);
    chk("both_empty_udf", 32'(udf), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_cleared", 32'(udf), 32'd0);

    // 100 pushes and 100 pops, crossing both thresholds and wrapping pointers.
    n_push = 0; n_pop = 0;
    for (int i = 0; i < 60; i++) begin seq++; cycle(1'b1, seq, 1'b0, 1'b0); end
    for (int i = 0; i < 56; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 2000 && (n_push < 100 || n_pop < 100); k++) begin
      logic w, r;
      w = (n_push < 100) && ($urandom_range(0, 1) == 1);
      r = (n_pop < 100) && (mdl_lvl > 0) && ($urandom_range(0, 1) == 1);
      if (w) seq++;
      cycle(w, seq, r, 1'b0);
    end
    chk("wrap_pushes", 32'(n_push), 32'd100);
    chk("wrap_pops", 32'(n_pop), 32'd100);

    // Flush beats a coincident write.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    @(posedge clk_i); #1;
    flush = 1'b0; wr_en = 1'b0;
    sb.delete();
    mdl_lvl = 0;
    chk_state();
    chk("flush_level", 32'(level), 32'd0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_empty", 32'(empty), 32'd1);

    // Asynchronous reset in the middle of traffic.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_ae", 32'(almost_empty), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_udf", 32'(udf), 32'd0);
`ifndef USB_EP_FIFO_FWFT_EN
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
`endif
    sb.delete();
    mdl_lvl = 0; mdl_ovf = 1'b0; mdl_udf = 1'b0; mdl_rd = 8'h00;
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk_state();
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
